// File: rtl/uart_arb_pkg.sv
// Shared constants for the uart_tx arbiter.
// State encoding, default sizing and a pointer helper.
package uart_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE      = 2'd0;
    localparam arb_state_t WAIT_DONE = 2'd1;
    localparam arb_state_t HOLD      = 2'd2;

    localparam int N_REQ_DEF        = 2;
    localparam int LOCK_TIMEOUT_DEF = 1_200_000;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Selects the first valid index at or after ptr, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int j;

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (valid[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                idx       = IW'(j);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between byte requesters.
// A grant is locked per packet until a last byte or an idle timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ        = N_REQ_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic [N_REQ-1:0]   grant,
    output logic               locked
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LOCK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 2);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    acc_idx;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    ptr_after;
    logic [N_REQ-1:0] pick_oh;
    logic             pick_any;
    logic             accept;
    logic             own_valid;
    logic             tmo;
    logic [CW-1:0]    cnt;
    logic [7:0]       req_byte [N_REQ];

    rr_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .onehot(pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    assign own_valid = req_valid[owner];
    // Release happens on the cycle the count would reach LOCK_TIMEOUT-1.
    assign tmo       = (cnt == CNT_LAST);
    assign ptr_after = IW'(wrap_inc(int'(owner), N_REQ));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = locked ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        acc_idx   = pick_idx;
        case (state)
            IDLE: begin
                if (!tx_busy && pick_any) begin
                    req_ready = pick_oh;
                    accept    = 1'b1;
                end
            end
            HOLD: begin
                if (!tx_busy && own_valid) begin
                    req_ready = grant;
                    accept    = 1'b1;
                    acc_idx   = owner;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            grant    <= '0;
            locked   <= 1'b0;
            rr_ptr   <= '0;
            owner    <= '0;
            cnt      <= '0;
        end else begin
            tx_start <= accept;
            if (accept) begin
                tx_data <= req_byte[acc_idx];
                grant   <= req_ready;
                owner   <= acc_idx;
                locked  <= ~req_last[acc_idx];
            end else if (state == WAIT_DONE && tx_done) begin
                if (locked) begin
                    cnt <= '0;
                end else begin
                    grant  <= '0;
                    rr_ptr <= ptr_after;
                end
            end else if (state == HOLD) begin
                if (tmo) begin
                    locked <= 1'b0;
                    grant  <= '0;
                    rr_ptr <= ptr_after;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural model plus directed scenarios.
// A small uart_tx model answers tx_start with busy/done.
module tb_uart_tx_arbiter;

    localparam int N  = 2;
    localparam int LT = 16;
    localparam int D  = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic           tx_done;
    logic [N-1:0]   grant;
    logic           locked;

    int cyc = 0;
    int errors;
    int checks;

    logic [7:0] sent [$];
    int         st_cyc [$];
    int         dn_cyc [$];
    int         lock_fall;
    int         last_acc;
    logic [7:0] cur_byte;
    bit         frame_valid;
    bit         u_force;
    int         rem;

    int         m_owner;
    int         m_ptr;
    int         m_rel;
    bit         m_lock;
    bit         m_wait;
    bit         m_accp;
    logic [7:0] m_data;
    logic       prev_locked;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_last (req_last),
        .req_ready(req_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .grant    (grant),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_rel   = 0;
        m_lock  = 1'b0;
        m_wait  = 1'b0;
        m_accp  = 1'b0;
        m_data  = 8'h00;
    endtask

    // Spec-level model: who may send now, and what the outputs must read.
    task automatic compare_cycle();
        logic [N-1:0] er;
        int win;
        if (rst) begin
            model_reset();
            prev_locked = 1'b0;
            return;
        end
        er  = '0;
        win = -1;
        if (!m_wait && !tx_busy) begin
            if (m_owner >= 0) begin
                if (req_valid[m_owner]) win = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && req_valid[(m_ptr + k) % N])
                        win = (m_ptr + k) % N;
                end
            end
        end
        if (win >= 0) er[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("grant", 32'(grant),
            (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("locked", 32'(locked), 32'(m_lock));
        chk("tx_start", 32'(tx_start), 32'(m_accp));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        if (prev_locked && !locked) lock_fall = cyc;
        prev_locked = locked;
        m_accp = 1'b0;
        if (win >= 0) begin
            m_owner = win;
            m_lock  = !req_last[win];
            m_wait  = 1'b1;
            m_accp  = 1'b1;
            m_data  = req_data[8*win +: 8];
        end else if (m_wait) begin
            if (tx_done) begin
                m_wait = 1'b0;
                if (m_lock) begin
                    m_rel = cyc + LT;
                end else begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
        end else if (m_owner >= 0 && cyc + 1 == m_rel) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_lock  = 1'b0;
        end
    endtask

    task automatic send(input int i, input int n, input bit fin,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2);
        logic [7:0] b;
        bit got;
        int w;
        for (int k = 0; k < n; k++) begin
            b = (k == 0) ? b0 : (k == 1) ? b1 : b2;
            req_valid[i]      = 1'b1;
            req_data[8*i +: 8] = b;
            req_last[i]       = (k == n - 1) ? fin : 1'b0;
            got = 1'b0;
            w   = 0;
            while (!got && w < 200) begin
                @(negedge clk);
                got = req_valid[i] && req_ready[i];
                w++;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL send_req%0d: got no ready expected accept", i);
            end else begin
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
    endtask

    task automatic clear_log();
        sent.delete();
        st_cyc.delete();
        dn_cyc.delete();
        lock_fall = -1;
    endtask

    task automatic wait_idle();
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_sent(input string nm, input int n,
                              input logic [7:0] e0, input logic [7:0] e1,
                              input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e;
        chk({nm, "_count"}, 32'(sent.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            e = (k == 0) ? e0 : (k == 1) ? e1 : (k == 2) ? e2 : e3;
            if (k < sent.size())
                chk($sformatf("%s_byte%0d", nm, k), 32'(sent[k]), 32'(e));
        end
    endtask

    task automatic chk_gap(input string nm, input int si, input int di,
                           input int exp);
        if (si < st_cyc.size() && di < dn_cyc.size()) begin
            chk(nm, 32'(st_cyc[si] - dn_cyc[di]), 32'(exp));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: got no frame expected gap %0d", nm, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk({nm, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({nm, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({nm, "_grant"}, 32'(grant), 32'd0);
        chk({nm, "_locked"}, 32'(locked), 32'd0);
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        tx_busy     = 1'b0;
        tx_done     = 1'b0;
        u_force     = 1'b0;
        frame_valid = 1'b0;
        cur_byte    = 8'h00;
        rem         = 0;
        errors      = 0;
        checks      = 0;
        last_acc    = 0;
        prev_locked = 1'b0;
        model_reset();
        clear_log();
        fork
            forever begin
                @(posedge clk);
                #1;
                if (!u_force) begin
                    if (tx_done) begin
                        tx_done = 1'b0;
                        tx_busy = 1'b0;
                    end
                    if (tx_start) begin
                        tx_busy     = 1'b1;
                        rem         = D;
                        cur_byte    = tx_data;
                        frame_valid = 1'b1;
                        sent.push_back(tx_data);
                        st_cyc.push_back(cyc);
                    end else if (tx_busy && rem > 0) begin
                        if (frame_valid)
                            chk("tx_data_hold", 32'(tx_data), 32'(cur_byte));
                        rem--;
                        if (rem == 0) begin
                            tx_done = 1'b1;
                            dn_cyc.push_back(cyc);
                        end
                    end
                end
            end
            forever begin
                @(negedge clk);
                compare_cycle();
            end
            begin
                repeat (30000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL watchdog: got no end expected finish");
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk_zero_outputs("reset");
                @(posedge clk);
                #1;

                clear_log();
                send(0, 1, 1'b1, 8'hAA, 8'h00, 8'h00);
                wait_idle();
                check_sent("single", 1, 8'hAA, 8'h00, 8'h00, 8'h00);
                if (st_cyc.size() > 0)
                    chk("single_latency", 32'(st_cyc[0] - last_acc), 32'd1);
                chk("single_grant_after", 32'(grant), 32'd0);

                u_force = 1'b1;
                tx_done = 1'b1;
                @(posedge clk);
                #1;
                tx_done = 1'b0;
                u_force = 1'b0;
                @(negedge clk);
                chk("stray_done_start", 32'(tx_start), 32'd0);
                @(posedge clk);
                #1;

                clear_log();
                fork
                    send(0, 1, 1'b1, 8'h11, 8'h00, 8'h00);
                    send(1, 1, 1'b1, 8'h22, 8'h00, 8'h00);
                join
                wait_idle();
                check_sent("ptr1", 2, 8'h22, 8'h11, 8'h00, 8'h00);

                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;

                clear_log();
                fork
                    send(0, 1, 1'b1, 8'h55, 8'h00, 8'h00);
                    send(1, 1, 1'b1, 8'hAA, 8'h00, 8'h00);
                join
                fork
                    send(0, 1, 1'b1, 8'h55, 8'h00, 8'h00);
                    send(1, 1, 1'b1, 8'hAA, 8'h00, 8'h00);
                join
                wait_idle();
                check_sent("contend", 4, 8'h55, 8'hAA, 8'h55, 8'hAA);

                clear_log();
                fork
                    send(1, 3, 1'b1, 8'hB1, 8'hB2, 8'hB3);
                    begin
                        @(posedge clk);
                        #1;
                        send(0, 1, 1'b1, 8'hC0, 8'h00, 8'h00);
                    end
                join
                wait_idle();
                check_sent("lock", 4, 8'hB1, 8'hB2, 8'hB3, 8'hC0);
                chk_gap("lock_gap", 3, 2, 2);

                clear_log();
                send(0, 1, 1'b0, 8'hD0, 8'h00, 8'h00);
                send(1, 1, 1'b1, 8'hE1, 8'h00, 8'h00);
                wait_idle();
                check_sent("timeout", 2, 8'hD0, 8'hE1, 8'h00, 8'h00);
                if (dn_cyc.size() > 0)
                    chk("timeout_release", 32'(lock_fall - dn_cyc[0]), 32'd16);
                chk_gap("timeout_next", 1, 0, 17);

                clear_log();
                send(0, 1, 1'b1, 8'hF0, 8'h00, 8'h00);
                @(posedge clk);
                #1;
                rst         = 1'b1;
                frame_valid = 1'b0;
                @(posedge clk);
                #1;
                rst = 1'b0;
                @(negedge clk);
                chk_zero_outputs("midreset");
                @(posedge clk);
                #1;
                fork
                    send(0, 1, 1'b1, 8'h90, 8'h00, 8'h00);
                    send(1, 1, 1'b1, 8'h91, 8'h00, 8'h00);
                join
                wait_idle();
                check_sent("midreset", 3, 8'hF0, 8'h90, 8'h91, 8'h00);
                chk_gap("midreset_gap", 1, 0, 2);

                clear_log();
                fork
                    send(0, 1, 1'b1, 8'h3C, 8'h00, 8'h00);
                    send(1, 1, 1'b1, 8'hC3, 8'h00, 8'h00);
                join
                wait_idle();
                check_sent("samecycle", 2, 8'h3C, 8'hC3, 8'h00, 8'h00);
                chk_gap("samecycle_gap", 1, 0, 2);
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
